fifo_memory_sync_pipelined: RTL

Single-clock dual-port FIFO storage array. It is the next generation of the FIFO memory used by the FIFO controllers. It extends the basic storage with:
- per-lane write enables
- a registered read port of configurable latency (1 or 2) with a read-valid qualifier
- a selectable read-during-write policy
- per-entry "written since reset" tracking, so reads of uninitialised locations are flagged instead of returning X.

It sits under the synchronous FIFO controller, which owns the pointers and the full/empty logic.

---
 rtl/fifo_memory_sync_pipelined.sv | 87 ++++++++
 1 files changed

// File: rtl/fifo_memory_sync_pipelined.sv
// fifo_memory_sync_pipelined: lane-masked dual-port FIFO storage with a 1- or 2-stage registered read port
// and a written-since-reset bitmap that flags reads of uninitialised or out-of-range entries.
module fifo_memory_sync_pipelined #(
  parameter int MEMORY_WIDTH = 32,
  parameter int MEMORY_DEPTH = 16,
  parameter int LANE_WIDTH = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE = 0,
  localparam int LANES = MEMORY_WIDTH / LANE_WIDTH,
  localparam int AW = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_en,
  input  logic [LANES-1:0]        write_lane_en,
  input  logic [AW-1:0]           write_addr,
  input  logic [MEMORY_WIDTH-1:0] write_data,
  input  logic                    read_en,
  input  logic [AW-1:0]           read_addr,
  output logic [MEMORY_WIDTH-1:0] read_data,
  output logic                    read_valid,
  output logic                    read_uninit
);
  localparam logic [AW:0] DEPTH = (AW+1)'(MEMORY_DEPTH);
  if (MEMORY_WIDTH % LANE_WIDTH != 0) begin : g_bad_lanes
    $error("MEMORY_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [MEMORY_DEPTH-1:0] written;
  logic                    wr_ok, rd_in, hit, a_uninit, p_valid, p_uninit;
  logic [MEMORY_WIDTH-1:0] a_data, p_data;
  assign wr_ok = write_en && |write_lane_en && ({1'b0, write_addr} < DEPTH);
  assign rd_in = {1'b0, read_addr} < DEPTH;
  assign hit   = RDW_MODE != 0 && wr_ok && write_addr == read_addr;
  always_ff @(posedge clk)
    if (!rst && wr_ok)
      for (int i = 0; i < LANES; i++)
        if (write_lane_en[i]) mem[write_addr][i*LANE_WIDTH +: LANE_WIDTH] <= write_data[i*LANE_WIDTH +: LANE_WIDTH];
  always_ff @(posedge clk)
    if (rst) written <= '0;
    else if (wr_ok) written[write_addr] <= 1'b1;
  // write-through merges only the lanes being written this edge; others keep the stored bytes
  always_comb begin
    a_data = rd_in ? mem[read_addr] : '0;
    for (int i = 0; i < LANES; i++)
      if (hit && write_lane_en[i]) a_data[i*LANE_WIDTH +: LANE_WIDTH] = write_data[i*LANE_WIDTH +: LANE_WIDTH];
    a_uninit = !rd_in || !(written[read_addr] || hit);
  end
  if (READ_LATENCY == 2) begin : g_stage
    logic                    s_valid, s_uninit;
    logic [MEMORY_WIDTH-1:0] s_data;
    always_ff @(posedge clk)
      if (rst) begin
        s_valid  <= 1'b0;
        s_uninit <= 1'b0;
        s_data   <= '0;
      end else begin
        s_valid <= read_en;
        if (read_en) begin
          s_uninit <= a_uninit;
          s_data   <= a_data;
        end
      end
    assign p_valid  = s_valid;
    assign p_uninit = s_uninit;
    assign p_data   = s_data;
  end else begin : g_direct
    assign p_valid  = read_en;
    assign p_uninit = a_uninit;
    assign p_data   = a_data;
  end
  always_ff @(posedge clk)
    if (rst) begin
      read_valid  <= 1'b0;
      read_uninit <= 1'b0;
      read_data   <= '0;
    end else begin
      read_valid <= p_valid;
      if (p_valid) begin
        read_uninit <= p_uninit;
        read_data   <= p_data;
      end
    end
endmodule
